// File: rtl/alu_result_bcd.sv
// ============================================================================
// Module   : alu_result_bcd
// Purpose  : Serial double-dabble conversion of the ALU result into packed BCD
//            with a leading-zero blank mask for the 7-segment driver.
//            Optional macro ALU_RESULT_SIGNED_EN: two's-complement input.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_result_bcd #(
  parameter int WIDTH  = 18,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      z,
  input  logic                  v,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  ovf,
  output logic                  neg
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [SW-1:0]     scratch;
  logic [WIDTH-1:0]  operand;
  logic [CW-1:0]     cnt;
  logic              v_q;
  logic              sign_q;

  logic [WIDTH-1:0]  mag;
  logic              sign;
  logic [SW-1:0]     adj;
  logic [SW+WIDTH-1:0] shifted;
  logic [DIGITS-1:0] mask;
  logic              run_zero;

`ifdef ALU_RESULT_SIGNED_EN
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  assign sign = z[WIDTH-1];
  assign mag  = z[WIDTH-1] ? (~z + ONE) : z;
`else
  assign sign = 1'b0;
  assign mag  = z;
`endif

  // Add-3 correction on every digit that would exceed 9 after doubling.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {adj, operand} << 1;

  // Digit 0 never blanks so a zero result still shows a single "0".
  always_comb begin
    mask     = '0;
    run_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run_zero = run_zero & (scratch[4*i +: 4] == 4'd0);
      mask[i]  = run_zero;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      scratch <= '0;
      operand <= '0;
      cnt     <= '0;
      v_q     <= 1'b0;
      sign_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      blank   <= '0;
      ovf     <= 1'b0;
      neg     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            operand <= mag;
            sign_q  <= sign;
            v_q     <= v;
            scratch <= '0;
            cnt     <= CNT_INIT;
            busy    <= 1'b1;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scratch <= shifted[SW+WIDTH-1:WIDTH];
          operand <= shifted[WIDTH-1:0];
          cnt     <= cnt - CNT_ONE;
          if (cnt == CNT_ONE)
            state <= S_DONE;
        end
        S_DONE: begin
          bcd   <= scratch;
          blank <= mask;
          ovf   <= v_q;
          neg   <= sign_q;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_bcd.sv
// ============================================================================
// Module   : tb_alu_result_bcd
// Purpose  : Directed and randomized self-checking bench for alu_result_bcd.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_result_bcd;

  logic        clk;
  logic        rst;
  logic        start;
  logic [17:0] z;
  logic        v;
  logic        busy;
  logic        done;
  logic [23:0] bcd;
  logic [5:0]  blank;
  logic        ovf;
  logic        neg;

  int errors;
  int checks;

  alu_result_bcd #(.WIDTH(18), .DIGITS(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .z     (z),
    .v     (v),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .blank (blank),
    .ovf   (ovf),
    .neg   (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference by repeated division.
  function automatic logic [23:0] ref_bcd(input logic [17:0] val);
    logic [23:0] b;
    int n;
    n = int'(val);
    b = '0;
    for (int i = 0; i < 6; i++) begin
      b[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return b;
  endfunction

  function automatic logic [5:0] ref_blank(input logic [17:0] val);
    logic [5:0] m;
    int p;
    m = '0;
    p = 1;
    for (int i = 1; i < 6; i++) begin
      p = p * 10;
      m[i] = (int'(val) < p);
    end
    return m;
  endfunction

  // Called at a negedge; returns at the negedge just after the sampling edge.
  task automatic do_start(input logic [17:0] zv, input logic vv);
    start = 1'b1;
    z     = zv;
    v     = vv;
    @(negedge clk);
    start = 1'b0;
    z     = $urandom_range(0, 262143);
    v     = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    z     = '0;
    v     = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, ovf, neg} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/ovf/neg=%b expected 0000", {busy, done, ovf, neg});
    end
    checks++;
    if (bcd !== 24'h0 || blank !== 6'b0) begin
      errors++;
      $display("FAIL reset_data: got bcd=%h blank=%b expected 000000/000000", bcd, blank);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero;
    int lat, bc;
    do_start(18'd0, 1'b0);
    wait_done(lat, bc);
    checks++;
    if (lat !== 19) begin
      errors++;
      $display("FAIL zero_latency: got %0d expected 19", lat);
    end
    checks++;
    if (bc !== 19) begin
      errors++;
      $display("FAIL zero_busy_cycles: got %0d expected 19", bc);
    end
    checks++;
    if (bcd !== 24'h000000 || blank !== 6'b111110 || ovf !== 1'b0 || neg !== 1'b0) begin
      errors++;
      $display("FAIL zero_result: got bcd=%h blank=%b ovf=%b neg=%b expected 000000/111110/0/0",
               bcd, blank, ovf, neg);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done_width: got done=%b busy=%b expected 0/0", done, busy);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    logic [23:0] exp_b;
    logic [5:0]  exp_m;
    logic        exp_n;
`ifdef ALU_RESULT_SIGNED_EN
    exp_b = 24'h000001; exp_m = 6'b111110; exp_n = 1'b1;
`else
    exp_b = 24'h262143; exp_m = 6'b000000; exp_n = 1'b0;
`endif
    do_start(18'd262143, 1'b0);
    wait_done(lat, bc);
    checks++;
    if (bcd !== exp_b || blank !== exp_m || neg !== exp_n || ovf !== 1'b0) begin
      errors++;
      $display("FAIL max_value: got bcd=%h blank=%b neg=%b ovf=%b expected %h/%b/%b/0",
               bcd, blank, neg, ovf, exp_b, exp_m, exp_n);
    end
    do_start(18'd12345, 1'b1);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b expected 1/0", busy, done);
    end
    wait_done(lat, bc);
    checks++;
    if (lat !== 19) begin
      errors++;
      $display("FAIL b2b_latency: got %0d expected 19", lat);
    end
    checks++;
    if (bcd !== 24'h012345 || blank !== 6'b100000 || ovf !== 1'b1 || neg !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result: got bcd=%h blank=%b ovf=%b neg=%b expected 012345/100000/1/0",
               bcd, blank, ovf, neg);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int lat, bc, extra;
    do_start(18'd100, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    z     = 18'd999;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    checks++;
    if (lat !== 14) begin
      errors++;
      $display("FAIL ignore_latency: got %0d remaining cycles expected 14", lat);
    end
    checks++;
    if (bcd !== 24'h000100 || blank !== 6'b111000) begin
      errors++;
      $display("FAIL ignore_result: got bcd=%h blank=%b expected 000100/111000", bcd, blank);
    end
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignore_second: got %0d active cycles expected 0", extra);
    end
    checks++;
    if (bcd !== 24'h000100) begin
      errors++;
      $display("FAIL ignore_hold: got bcd=%h expected 000100", bcd);
    end
  endtask

  task automatic test_mid_reset;
    int lat, bc, seen;
    do_start(18'd54321, 1'b1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, ovf, neg} !== 4'b0000 || bcd !== 24'h0 || blank !== 6'b0) begin
      errors++;
      $display("FAIL midreset_clear: got busy=%b done=%b bcd=%h blank=%b ovf=%b neg=%b expected all 0",
               busy, done, bcd, blank, ovf, neg);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_abandon: got %0d active cycles expected 0", seen);
    end
    do_start(18'd7, 1'b0);
    wait_done(lat, bc);
    checks++;
    if (lat !== 19 || bcd !== 24'h000007 || blank !== 6'b111110) begin
      errors++;
      $display("FAIL midreset_restart: got lat=%0d bcd=%h blank=%b expected 19/000007/111110",
               lat, bcd, blank);
    end
    @(negedge clk);
  endtask

  task automatic test_signed;
    int lat, bc;
    logic [23:0] exp_b;
    logic        exp_n;
`ifdef ALU_RESULT_SIGNED_EN
    exp_b = 24'h000001; exp_n = 1'b1;
`else
    exp_b = 24'h262143; exp_n = 1'b0;
`endif
    do_start(18'h3FFFF, 1'b0);
    wait_done(lat, bc);
    checks++;
    if (bcd !== exp_b || neg !== exp_n) begin
      errors++;
      $display("FAIL sign_all_ones: got bcd=%h neg=%b expected %h/%b", bcd, neg, exp_b, exp_n);
    end
    @(negedge clk);
`ifdef ALU_RESULT_SIGNED_EN
    exp_b = 24'h131072; exp_n = 1'b1;
`else
    exp_b = 24'h131072; exp_n = 1'b0;
`endif
    do_start(18'h20000, 1'b0);
    wait_done(lat, bc);
    checks++;
    if (bcd !== exp_b || neg !== exp_n || blank !== 6'b000000) begin
      errors++;
      $display("FAIL sign_min: got bcd=%h neg=%b blank=%b expected %h/%b/000000",
               bcd, neg, blank, exp_b, exp_n);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep;
    int lat, bc, bad;
    logic [17:0] val, mag;
    logic        vv, sg;
    for (int n = 0; n < 1000; n++) begin
      val = 18'($urandom_range(0, 262143));
      if (n == 0) val = 18'd9;
      if (n == 1) val = 18'd10;
      if (n == 2) val = 18'd99999;
      if (n == 3) val = 18'd100000;
      vv = 1'($urandom_range(0, 1));
`ifdef ALU_RESULT_SIGNED_EN
      sg  = val[17];
      mag = val[17] ? (~val + 18'd1) : val;
`else
      sg  = 1'b0;
      mag = val;
`endif
      do_start(val, vv);
      wait_done(lat, bc);
      checks++;
      if (lat !== 19) begin
        errors++;
        $display("FAIL sweep_latency: z=%0d got %0d expected 19", val, lat);
      end
      bad = 0;
      for (int d = 0; d < 6; d++)
        if (bcd[4*d +: 4] > 4'd9) bad++;
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL sweep_digit_range: z=%0d got bcd=%h with %0d invalid digits", val, bcd, bad);
      end
      checks++;
      if (bcd !== ref_bcd(mag) || blank !== ref_blank(mag) || ovf !== vv || neg !== sg) begin
        errors++;
        $display("FAIL sweep_value: z=%0d got bcd=%h blank=%b ovf=%b neg=%b expected %h/%b/%b/%b",
                 val, bcd, blank, ovf, neg, ref_bcd(mag), ref_blank(mag), vv, sg);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL sweep_done_width: z=%0d got done=%b expected 0", val, done);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset;
    test_zero;
    test_back_to_back;
    test_ignore_start;
    test_mid_reset;
    test_signed;
    test_sweep;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_result_bcd.md
Name: alu_result_bcd

Overview:
- Downstream stage of the 18-bit calculator ALU.
- Captures the ALU result z and the overflow flag v on a start strobe.
- Converts the result to 6 packed BCD digits with an iterative shift-add-3 (double-dabble) sequence, one bit per clock.
- Also produces a leading-zero blank mask, so the 7-segment display driver can consume the output directly.

Parameters:
- WIDTH, 18, binary input width; must match the ALU result width.
- DIGITS, 6, number of BCD output digits; 6 covers 0..262143.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; samples z and v.
- z  input  WIDTH  ALU result to convert.
- v  input  1  ALU overflow flag accompanying z.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse; bcd, blank, ovf and neg are valid/updated.
- bcd  output  4*DIGITS  packed BCD; digit 0 is bcd[3:0] (least significant).
- blank  output  DIGITS  1 = digit is a leading zero and should be blanked.
- ovf  output  1  registered copy of v for the result in bcd.
- neg  output  1  result sign; tied 0 unless SIGNED_EN is defined.

Behaviour:
- Reset (async, any time, including mid-conversion):
  - state = IDLE; busy = 0, done = 0, bcd = 0, blank = 0, ovf = 0, neg = 0.
  - Shift register and iteration counter cleared; the in-flight conversion is abandoned.
- State IDLE:
  - start = 1 at edge N: capture operand = z (or its magnitude, see Optional Feature), v_q = v.
  - Clear the BCD scratch register and set cnt = WIDTH.
  - busy = 1 from edge N; go to SHIFT.
- State SHIFT, one iteration per edge, WIDTH iterations at edges N+1..N+WIDTH:
  - Each scratch digit >= 5 gets +3, evaluated combinationally on the current scratch value.
  - Then {scratch, operand} shifts left 1; the operand MSB enters scratch bit 0.
  - cnt decrements each iteration; when cnt reaches 0, go to DONE.
- State DONE, edge N+WIDTH+1:
  - bcd <= scratch; ovf <= v_q; neg <= captured sign; blank <= computed mask; done = 1 for this cycle only.
  - busy = 0; return to IDLE.
- Latency: done rises exactly WIDTH+1 = 19 cycles after the edge that sampled start.
- start while busy = 1, or in the DONE cycle: ignored, no queueing.
- start in the cycle after done: accepted normally, so back-to-back conversions take 20 cycles each.
- Output hold: bcd, blank, ovf and neg hold their last values between done pulses; they never show intermediate scratch values.
- Blank mask:
  - blank[i] = 1 iff digit i and every higher digit are zero, for i = DIGITS-1 down to 1.
  - blank[0] is always 0, so zero displays as "0".
- Width rule: scratch is 4*DIGITS bits. Values up to 2^WIDTH-1 = 262143 never overflow 6 digits, so no saturation logic is needed.
- z and v may change freely after the sampling edge; only captured copies are used.

Optional Feature:
- Macro: ALU_RESULT_SIGNED_EN.
- Defined:
  - z is treated as two's complement.
  - At capture, neg = z[WIDTH-1] and operand = |z|, computed as (~z + 1) when negative.
  - z = 18'h20000 gives magnitude 131072 and neg = 1.
  - neg is registered at DONE together with bcd.
- Not defined:
  - z is unsigned; operand = z; neg is held at 0.
  - No negation logic is synthesized.

Test Plan:
- Reset, then start with z = 0 -> done exactly 19 cycles after the sampling edge; bcd = 24'h000000, blank = 6'b111110, ovf = 0, busy high for 19 cycles.
- start with z = 262143, v = 0 -> bcd = 24'h262143, blank = 6'b000000; then immediately start with z = 12345, v = 1 -> bcd = 24'h012345, blank = 6'b100000, ovf = 1.
- start with z = 100, then pulse start with z = 999 at cycle 5 of busy -> single done; bcd = 24'h000100; second start is ignored.
- Assert rst at cycle 10 of a conversion of z = 54321 -> all outputs 0 immediately, no done pulse; a fresh start with z = 7 -> bcd = 24'h000007, blank = 6'b111110.
- With ALU_RESULT_SIGNED_EN, z = 18'h3FFFF -> neg = 1, bcd = 24'h000001; z = 18'h20000 -> neg = 1, bcd = 24'h131072. Without the macro, z = 18'h3FFFF -> neg = 0, bcd = 24'h262143.
- Randomized sweep of 1000 values of z against a reference decimal conversion -> every digit is <= 9 and the value matches; done pulse is exactly 1 cycle wide.
